vga_pattern_gen: RTL
====================

// Module: vga_pattern_gen
// PURPOSE
//  Multi-mode VGA test-pattern generator; successor to the fixed 10-bar colour source.
//  Inputs: pixel coordinates from the VGA timing controller. Output: RGB565 pic_data, registered.
//  Modes: vertical bars, horizontal bars, checkerboard, scrolling vertical bars.
//  Mode changes apply only at frame boundaries, so no frame tears.
// PARAMETERS
//  H_VALID      640  active pixels per line
//  V_VALID      480  active lines per frame
//  BAR_NUM      10   bar count, legal range 2..10 (palette size)
//  CHECK_SHIFT  5    checker square = 2**CHECK_SHIFT px
//  SCROLL_DIV   4    frames per scroll step, >=1
// PORTS
//  vga_clk    in   1   pixel clock
//  rst_n      in   1   async active-low reset
//  pic_valid  in   1   coordinates are inside the active area this cycle
//  pic_x      in   10  column, 0..H_VALID-1; steps +1 per valid cycle
//  pic_y      in   10  row, 0..V_VALID-1
//  mode_sel   in   2   requested mode: 0 VBAR, 1 HBAR, 2 CHECK, 3 SCROLL
//  mode_req   in   1   1-cycle pulse; captures mode_sel
//  pic_data   out  16  RGB565 pixel, 1 cycle after the coordinates
//  mode_cur   out  2   mode currently displayed
// BEHAVIOUR
//  Clock and reset:
//   - One clock (vga_clk). rst_n is asynchronous and active-low.
//   - Reset values: pic_data=0, mode_cur=0, pend_mode=0, pend_vld=0, bar/pos counters=0, scroll_ofs=0, frm_cnt=0.
//  Latency and blanking:
//   - pic_data registered, latency exactly 1 cycle.
//   - pic_valid=0 -> pic_data=BLACK next cycle; counters hold.
//  Bar widths:
//   - BAR_W = H_VALID/BAR_NUM, BAR_H = V_VALID/BAR_NUM, integer-truncated.
//   - Remainder pixels at the right/bottom edge take colour of bar BAR_NUM-1.
//  Bar tracking (no dividers):
//   - x counter: when pic_valid and pic_x==0, xbar=0 and xpos=0.
//     Otherwise xpos advances by 1; at BAR_W-1 it wraps to 0 and xbar increments, saturating at BAR_NUM-1.
//   - y counter: same scheme, advanced once per line at pic_x==H_VALID-1.
//     Reset to 0 at pic_y==0 and pic_x==0.
//   - Colour lookup uses the updated (next) index, so the pixel at x=BAR_W is already bar 1.
//  Pixel colour by mode:
//   - VBAR:   PALETTE[xbar].
//   - HBAR:   PALETTE[ybar].
//   - CHECK:  (pic_x[CHECK_SHIFT]^pic_y[CHECK_SHIFT]) ? WHITE : BLACK.
//   - SCROLL: PALETTE[(xbar+scroll_ofs) mod BAR_NUM]; modulo is one conditional subtract.
//  Frame end:
//   - fe = pic_valid && pic_x==H_VALID-1 && pic_y==V_VALID-1.
//  Mode change:
//   - mode_req sets pend_mode=mode_sel and pend_vld=1.
//   - A later mode_req before fe overwrites pend_mode; the last request wins.
//   - At fe with pend_vld: mode_cur<=pend_mode, pend_vld<=0. The new mode is visible from pixel (0,0).
//   - mode_req in the same cycle as fe: that request is latched and applied at the next fe, not this one.
//   - Requesting the mode already displayed is legal; no visible effect.
//  Scroll:
//   - frm_cnt counts fe events 0..SCROLL_DIV-1.
//   - At wrap, scroll_ofs increments mod BAR_NUM (BAR_NUM-1 -> 0).
//   - Counting runs in every mode; scroll_ofs is cleared when mode_cur changes to SCROLL.
//  Mid-frame reset: all state is cleared; output resumes correctly from the next pic_x==0.
// STRUCTURE
//  vga_pattern_pkg:
//   - RGB565 palette: RED F800, ORANGE FC00, YELLOW FFE0, GREEN 07E0, CYAN 07FF,
//     BLUE 001F, PURPLE F81F, BLACK 0000, WHITE FFFF, GRAY D69A.
//   - Mode encodings MODE_VBAR..MODE_SCROLL.
//  Sub-module vga_bar_counter (params LEN, NUM; ports clr, adv -> idx, pos), instantiated twice (x, y).
//  Top level holds mode/pending registers, frame/scroll counters, colour mux and output register.
// TESTING
//  1. Reset, mode 0, full frame: x=0..63 -> F800; x=64 -> FC00; x=639 -> D69A; pic_valid=0 -> 0000.
//  2. mode_req with mode_sel=1 mid-frame: rest of the frame stays VBAR, mode_cur stays 0.
//     Next frame: rows 0..47 = F800, row 48 = FC00; mode_cur=1.
//  3. Mode 2: (0,0) -> 0000, (32,0) -> FFFF, (32,32) -> 0000.
//  4. Mode 3, SCROLL_DIV=4: frames 0-3 show x=0 -> F800; frame 4 x=0 -> FC00.
//     After 40 frames the pattern is back to F800.
//  5. mode_req coincident with fe: mode_cur unchanged at that fe, updates at the following fe.
//     Two requests in one frame: the last wins.
//  6. rst_n low mid-line at x=300: pic_data=0 asynchronously.
//     After release, next line correct from x=0. Also repeat with BAR_NUM=8: bar width 80, x=80 -> ORANGE.

Source files
------------

// File: rtl/vga_pattern_pkg.sv
// Shared definitions for the VGA test-pattern generator.
//   - coordinate and bar-index widths
//   - RGB565 colour constants and the bar palette lookup
//   - display mode encoding
package vga_pattern_pkg;

    localparam int COORD_W = 10;  // pic_x / pic_y width
    localparam int IDX_W   = 4;   // bar index width, holds 0..9

    localparam logic [15:0] RGB_RED    = 16'hF800;
    localparam logic [15:0] RGB_ORANGE = 16'hFC00;
    localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
    localparam logic [15:0] RGB_GREEN  = 16'h07E0;
    localparam logic [15:0] RGB_CYAN   = 16'h07FF;
    localparam logic [15:0] RGB_BLUE   = 16'h001F;
    localparam logic [15:0] RGB_PURPLE = 16'hF81F;
    localparam logic [15:0] RGB_BLACK  = 16'h0000;
    localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
    localparam logic [15:0] RGB_GRAY   = 16'hD69A;

    typedef enum logic [1:0] {
        MODE_VBAR   = 2'd0,
        MODE_HBAR   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

    // Bar colour for a bar index; indices past the 10-entry palette are black.
    function automatic logic [15:0] palette(input logic [IDX_W-1:0] idx);
        case (idx)
            4'd0:    palette = RGB_RED;
            4'd1:    palette = RGB_ORANGE;
            4'd2:    palette = RGB_YELLOW;
            4'd3:    palette = RGB_GREEN;
            4'd4:    palette = RGB_CYAN;
            4'd5:    palette = RGB_BLUE;
            4'd6:    palette = RGB_PURPLE;
            4'd7:    palette = RGB_BLACK;
            4'd8:    palette = RGB_WHITE;
            4'd9:    palette = RGB_GRAY;
            default: palette = RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_pattern_gen_bar.sv
// Divider-free bar tracker: counts pixels (or lines) inside the current bar
// and steps the bar index every LEN advances, saturating at NUM-1 so the
// remainder pixels past the last full bar keep the last bar's colour.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   clr         restart at bar 0 (has priority over adv)
//   adv         advance one pixel/line
//   idx         bar index AFTER this cycle's clr/adv (combinational next state)
//   pos         position inside the bar AFTER this cycle's clr/adv
module vga_bar_counter
    import vga_pattern_pkg::*;
#(
    parameter int LEN = 64,
    parameter int NUM = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               adv,
    output logic [IDX_W-1:0]   idx,
    output logic [COORD_W-1:0] pos
);
    localparam logic [COORD_W-1:0] POS_LAST = COORD_W'(LEN - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM - 1);

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COORD_W-1:0] pos_q, pos_d;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        idx_d = idx_q;
        pos_d = pos_q;
        if (clr) begin
            idx_d = '0;
            pos_d = '0;
        end else if (adv) begin
            if (pos_q == POS_LAST) begin
                pos_d = '0;
                if (idx_q != IDX_LAST) idx_d = idx_q + 1'b1;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            pos_q <= '0;
        end else begin
            idx_q <= idx_d;
            pos_q <= pos_d;
        end
    end

    // Exposing the next state lets the pixel at x=LEN already see bar 1.
    assign idx = idx_d;
    assign pos = pos_d;

endmodule

// File: rtl/vga_pattern_gen.sv
// Multi-mode VGA test-pattern generator (vertical bars, horizontal bars,
// checkerboard, scrolling vertical bars) with frame-synchronous mode switch.
// Ports:
//   vga_clk, rst_n   pixel clock, async active-low reset
//   pic_valid        coordinates are in the active area this cycle
//   pic_x, pic_y     active-area coordinates (pic_x steps +1 per valid cycle)
//   mode_sel         requested mode, captured on mode_req
//   mode_req         one-cycle request pulse
//   pic_data         registered RGB565 pixel, one cycle after the coordinates
//   mode_cur         mode currently on screen
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int H_VALID     = 640,
    parameter int V_VALID     = 480,
    parameter int BAR_NUM     = 10,
    parameter int CHECK_SHIFT = 5,
    parameter int SCROLL_DIV  = 4
) (
    input  logic               vga_clk,
    input  logic               rst_n,
    input  logic               pic_valid,
    input  logic [COORD_W-1:0] pic_x,
    input  logic [COORD_W-1:0] pic_y,
    input  logic [1:0]         mode_sel,
    input  logic               mode_req,
    output logic [15:0]        pic_data,
    output logic [1:0]         mode_cur
);
    localparam int BAR_W = H_VALID / BAR_NUM;
    localparam int BAR_H = V_VALID / BAR_NUM;
    localparam int FRM_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int SUM_W = IDX_W + 1;

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_VALID - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_VALID - 1);
    localparam logic [FRM_W-1:0]   FRM_LAST = FRM_W'(SCROLL_DIV - 1);
    localparam logic [IDX_W-1:0]   OFS_LAST = IDX_W'(BAR_NUM - 1);
    localparam logic [SUM_W-1:0]   NUM_EXT  = SUM_W'(BAR_NUM);

    logic [15:0]      pic_data_q, pic_data_d;
    mode_e            mode_q, mode_d;
    mode_e            pend_mode_q, pend_mode_d;
    logic             pend_vld_q, pend_vld_d;
    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
    logic [IDX_W-1:0] scroll_ofs_q, scroll_ofs_d;
    logic [IDX_W-1:0] row_bar_q, row_bar_d;

    logic               x_clr, y_clr, y_adv, fe;
    logic [IDX_W-1:0]   x_idx, y_idx;
    logic [COORD_W-1:0] x_pos_unused, y_pos_unused;
    logic [SUM_W-1:0]   scroll_sum;
    logic [IDX_W-1:0]   scroll_idx;
    logic [15:0]        colour;

    assign x_clr = pic_valid && (pic_x == '0);
    assign y_clr = x_clr && (pic_y == '0);
    assign y_adv = pic_valid && (pic_x == X_LAST);
    assign fe    = y_adv && (pic_y == Y_LAST);

    vga_bar_counter #(.LEN(BAR_W), .NUM(BAR_NUM)) u_xbar (
        .clk   (vga_clk),
        .rst_n (rst_n),
        .clr   (x_clr),
        .adv   (pic_valid),
        .idx   (x_idx),
        .pos   (x_pos_unused)
    );

    vga_bar_counter #(.LEN(BAR_H), .NUM(BAR_NUM)) u_ybar (
        .clk   (vga_clk),
        .rst_n (rst_n),
        .clr   (y_clr),
        .adv   (y_adv),
        .idx   (y_idx),
        .pos   (y_pos_unused)
    );

    // Colour selection. The y counter steps on the last pixel of a line, so
    // its next-state value already points at the following line there; the
    // row's bar is therefore sampled at x=0 and held for the whole line.
    always_comb begin
        row_bar_d  = x_clr ? y_idx : row_bar_q;
        scroll_sum = SUM_W'(x_idx) + SUM_W'(scroll_ofs_q);
        // Both operands are below BAR_NUM, so one subtract completes the modulo.
        scroll_idx = (scroll_sum >= NUM_EXT) ? IDX_W'(scroll_sum - NUM_EXT)
                                             : IDX_W'(scroll_sum);
        colour = RGB_BLACK;
        case (mode_q)
            MODE_VBAR:   colour = palette(x_idx);
            MODE_HBAR:   colour = palette(row_bar_d);
            MODE_CHECK:  colour = (pic_x[CHECK_SHIFT] ^ pic_y[CHECK_SHIFT]) ? RGB_WHITE : RGB_BLACK;
            MODE_SCROLL: colour = palette(scroll_idx);
            default:     colour = RGB_BLACK;
        endcase
        pic_data_d = pic_valid ? colour : RGB_BLACK;
    end

    // Mode request, frame-boundary switch and scroll offset.
    always_comb begin
        mode_d       = mode_q;
        pend_mode_d  = pend_mode_q;
        pend_vld_d   = pend_vld_q;
        frm_cnt_d    = frm_cnt_q;
        scroll_ofs_d = scroll_ofs_q;
        if (fe) begin
            if (frm_cnt_q == FRM_LAST) begin
                frm_cnt_d    = '0;
                scroll_ofs_d = (scroll_ofs_q == OFS_LAST) ? '0 : scroll_ofs_q + 1'b1;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
            if (pend_vld_q) begin
                mode_d     = pend_mode_q;
                pend_vld_d = 1'b0;
                // Entering scroll mode always starts from an unshifted pattern.
                if (pend_mode_q == MODE_SCROLL && mode_q != MODE_SCROLL) scroll_ofs_d = '0;
            end
        end
        // Placed after the fe handling: a request in the fe cycle survives
        // the clear of pend_vld and waits for the next frame end.
        if (mode_req) begin
            pend_mode_d = mode_e'(mode_sel);
            pend_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            pic_data_q   <= RGB_BLACK;
            mode_q       <= MODE_VBAR;
            pend_mode_q  <= MODE_VBAR;
            pend_vld_q   <= 1'b0;
            frm_cnt_q    <= '0;
            scroll_ofs_q <= '0;
            row_bar_q    <= '0;
        end else begin
            pic_data_q   <= pic_data_d;
            mode_q       <= mode_d;
            pend_mode_q  <= pend_mode_d;
            pend_vld_q   <= pend_vld_d;
            frm_cnt_q    <= frm_cnt_d;
            scroll_ofs_q <= scroll_ofs_d;
            row_bar_q    <= row_bar_d;
        end
    end

    assign pic_data = pic_data_q;
    assign mode_cur = mode_q;

endmodule
